// File: rtl/bp_common_pkg.sv
// Shared profiler definitions: stall-reason codes and histogram bin layout.
package bp_common_pkg;

  localparam int stall_reason_width_gp = 5;

  typedef enum logic [stall_reason_width_gp-1:0] {
    e_stall_interrupt       = 5'd0,
    e_stall_icache_miss     = 5'd1,
    e_stall_icache_fence    = 5'd2,
    e_stall_branch_override = 5'd3,
    e_stall_dcache_miss     = 5'd4,
    e_stall_dcache_fence    = 5'd5,
    e_stall_long_haz        = 5'd6,
    e_stall_control_haz     = 5'd7,
    e_stall_data_haz        = 5'd8,
    e_stall_load_dep        = 5'd9,
    e_stall_mul_dep         = 5'd10,
    e_stall_fma_dep         = 5'd11,
    e_stall_sb_raw          = 5'd12,
    e_stall_struct_haz      = 5'd13,
    e_stall_mispredict      = 5'd14,
    e_stall_exception       = 5'd15,
    e_stall_eret            = 5'd16,
    e_stall_fence           = 5'd17,
    e_stall_cmd_fence       = 5'd18,
    e_stall_freeze          = 5'd19
  } bp_stall_reason_e;

  localparam int num_stall_reasons_gp = 20;

  // Extra bins appended after the reason bins
  localparam int stall_bin_instr_gp   = 20;
  localparam int stall_bin_unknown_gp = 21;
  localparam int stall_bin_total_gp   = 22;
  localparam int num_stall_bins_gp    = num_stall_reasons_gp + 3;

  typedef enum logic {
    e_hist_idle = 1'b0,
    e_hist_resp = 1'b1
  } bp_stall_hist_state_e;

endpackage

// File: rtl/bp_stall_counter.sv
// Single saturating event counter with clear; a simultaneous increment
// during a clear leaves the counter at 1 so no event is lost.
module bp_stall_counter #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_li,
  input  logic               inc_i,
  input  logic               clr_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_r, count_n;
  logic               sat_w;

  assign sat_w = &count_r;

  always_comb begin
    count_n = count_r;
    if (clr_i)
      count_n = inc_i ? width_p'(1) : '0;
    else if (inc_i && !sat_w)
      count_n = count_r + width_p'(1);
  end

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li)
      count_r <= '0;
    else
      count_r <= count_n;
  end

  assign count_o = count_r;

endmodule

// File: rtl/bp_stall_histogram.sv
// Per-cycle stall-reason histogram with a one-outstanding read/clear port.
module bp_stall_histogram
  import bp_common_pkg::*;
#(
  parameter int num_reasons_p = num_stall_reasons_gp,
  parameter int cnt_width_p   = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_li,
  input  logic                   en_i,
  input  logic                   commit_v_i,
  input  logic                   stall_v_i,
  input  logic [4:0]             stall_reason_i,
  input  logic                   req_v_i,
  output logic                   req_ready_o,
  input  logic [4:0]             req_idx_i,
  input  logic                   req_clear_i,
  output logic                   resp_v_o,
  input  logic                   resp_ready_i,
  output logic [cnt_width_p-1:0] resp_data_o,
  output logic                   resp_err_o
);

  // Extra bins keep their offset from the reason bins as reason count varies
  localparam int num_bins_lp    = num_reasons_p + (num_stall_bins_gp - num_stall_reasons_gp);
  localparam int instr_bin_lp   = num_reasons_p + (stall_bin_instr_gp - num_stall_reasons_gp);
  localparam int unknown_bin_lp = num_reasons_p + (stall_bin_unknown_gp - num_stall_reasons_gp);
  localparam int total_bin_lp   = num_reasons_p + (stall_bin_total_gp - num_stall_reasons_gp);

  bp_stall_hist_state_e state_r, state_n;
  logic                   ready_r;
  logic                   req_fire_w;
  logic                   idx_valid_w;
  int                     cls_bin_w;
  logic [num_bins_lp-1:0] inc_w, clr_w;
  logic [cnt_width_p-1:0] count_w [num_bins_lp];
  logic [cnt_width_p-1:0] rd_data_w;
  logic [cnt_width_p-1:0] resp_data_r;
  logic                   resp_err_r;

  assign req_fire_w  = req_v_i & req_ready_o;
  assign idx_valid_w = int'(req_idx_i) < num_bins_lp;

  always_comb begin
    cls_bin_w = unknown_bin_lp;
    if (commit_v_i)
      cls_bin_w = instr_bin_lp;
    else if (stall_v_i && (int'(stall_reason_i) < num_reasons_p))
      cls_bin_w = int'(stall_reason_i);
  end

  genvar gi;
  generate
    for (gi = 0; gi < num_bins_lp; gi++) begin : g_bin
      if (gi == total_bin_lp) begin : g_total
        assign inc_w[gi] = en_i;
      end else begin : g_class
        assign inc_w[gi] = en_i & (cls_bin_w == gi);
      end
      assign clr_w[gi] = req_fire_w & req_clear_i & (int'(req_idx_i) == gi);

      bp_stall_counter #(
        .width_p(cnt_width_p)
      ) counter (
        .clk_i   (clk_i),
        .reset_li(reset_li),
        .inc_i   (inc_w[gi]),
        .clr_i   (clr_w[gi]),
        .count_o (count_w[gi])
      );
    end
  endgenerate

  // Out-of-range indices fall through to zero
  always_comb begin
    rd_data_w = '0;
    for (int i = 0; i < num_bins_lp; i++)
      if (int'(req_idx_i) == i)
        rd_data_w = count_w[i];
  end

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li)
      state_r <= e_hist_idle;
    else
      state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_hist_idle: if (req_fire_w)   state_n = e_hist_resp;
      e_hist_resp: if (resp_ready_i) state_n = e_hist_idle;
      default:                       state_n = e_hist_idle;
    endcase
  end

  always_comb begin
    req_ready_o = (state_r == e_hist_idle) & ready_r;
    resp_v_o    = (state_r == e_hist_resp);
  end

  // Holds ready low until the first clock edge after reset release
  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li)
      ready_r <= 1'b0;
    else
      ready_r <= 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      resp_data_r <= '0;
      resp_err_r  <= 1'b0;
    end else if (req_fire_w) begin
      resp_data_r <= rd_data_w;
      resp_err_r  <= ~idx_valid_w;
    end
  end

  assign resp_data_o = resp_data_r;
  assign resp_err_o  = resp_err_r;

endmodule

// File: tb/tb_bp_stall_histogram.sv
// Directed bench for bp_stall_histogram: 32-bit instance plus a 4-bit one for saturation.
module tb_bp_stall_histogram;

  logic       clk = 1'b0;
  logic       reset_li;
  logic       en, en4, commit, commit4, stall_v;
  logic [4:0] reason;
  logic       req_v, req_clear, resp_ready, sel4;
  logic [4:0] req_idx;

  logic        req_ready0, resp_v0, resp_err0;
  logic [31:0] resp_data0;
  logic        req_ready4, resp_v4, resp_err4;
  logic [3:0]  resp_data4;

  logic        req_ready_m, resp_v_m, resp_err_m;
  logic [31:0] resp_data_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_stall_histogram #(.num_reasons_p(20), .cnt_width_p(32)) dut (
    .clk_i         (clk),
    .reset_li      (reset_li),
    .en_i          (en),
    .commit_v_i    (commit),
    .stall_v_i     (stall_v),
    .stall_reason_i(reason),
    .req_v_i       (req_v & ~sel4),
    .req_ready_o   (req_ready0),
    .req_idx_i     (req_idx),
    .req_clear_i   (req_clear),
    .resp_v_o      (resp_v0),
    .resp_ready_i  (resp_ready & ~sel4),
    .resp_data_o   (resp_data0),
    .resp_err_o    (resp_err0)
  );

  bp_stall_histogram #(.num_reasons_p(20), .cnt_width_p(4)) dut4 (
    .clk_i         (clk),
    .reset_li      (reset_li),
    .en_i          (en4),
    .commit_v_i    (commit4),
    .stall_v_i     (stall_v),
    .stall_reason_i(reason),
    .req_v_i       (req_v & sel4),
    .req_ready_o   (req_ready4),
    .req_idx_i     (req_idx),
    .req_clear_i   (req_clear),
    .resp_v_o      (resp_v4),
    .resp_ready_i  (resp_ready & sel4),
    .resp_data_o   (resp_data4),
    .resp_err_o    (resp_err4)
  );

  assign req_ready_m = sel4 ? req_ready4 : req_ready0;
  assign resp_v_m    = sel4 ? resp_v4 : resp_v0;
  assign resp_err_m  = sel4 ? resp_err4 : resp_err0;
  assign resp_data_m = sel4 ? {28'b0, resp_data4} : resp_data0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full request/response transaction; en is driven to en_acc only in the acceptance cycle
  task automatic read_bin(input logic use4, input logic [4:0] idx, input logic clr,
                          input logic en_acc, output logic [31:0] data, output logic err);
    int n;
    sel4 = use4; req_idx = idx; req_clear = clr; req_v = 1'b1;
    n = 0;
    while (!req_ready_m && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("req_ready idx%0d", idx), {31'b0, req_ready_m}, 32'd1);
    en = en_acc;
    @(negedge clk);
    en = 1'b0; req_v = 1'b0; req_clear = 1'b0;
    chk($sformatf("resp_v latency idx%0d", idx), {31'b0, resp_v_m}, 32'd1);
    chk($sformatf("ready low in resp idx%0d", idx), {31'b0, req_ready_m}, 32'd0);
    data = resp_data_m;
    err  = resp_err_m;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk($sformatf("resp_v drop idx%0d", idx), {31'b0, resp_v_m}, 32'd0);
    $display("read dut%0d bin %0d clear %0d -> data %0d err %0d", use4 ? 4 : 32, idx, clr, data, err);
  endtask

  task automatic expect_bin(input logic use4, input logic [4:0] idx, input logic clr,
                            input logic en_acc, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    read_bin(use4, idx, clr, en_acc, d, e);
    chk($sformatf("bin%0d data dut%0d", idx, use4 ? 4 : 32), d, exp);
    chk($sformatf("bin%0d err", idx), {31'b0, e}, 32'd0);
  endtask

  initial begin
    reset_li = 1'b0; en = 0; en4 = 0; commit = 0; commit4 = 0; stall_v = 0; reason = '0;
    req_v = 0; req_clear = 0; resp_ready = 0; sel4 = 0; req_idx = '0;

    repeat (2) @(negedge clk);
    chk("reset resp_v", {31'b0, resp_v0}, 32'd0);
    chk("reset req_ready", {31'b0, req_ready0}, 32'd0);
    chk("reset resp_data", resp_data0, 32'd0);
    chk("reset resp_err", {31'b0, resp_err0}, 32'd0);
    reset_li = 1'b1;
    @(negedge clk);
    chk("ready after reset", {31'b0, req_ready0}, 32'd1);
    $display("reset released");

    // 10 commit cycles
    en = 1; commit = 1;
    repeat (10) @(negedge clk);
    en = 0; commit = 0;
    expect_bin(0, 5'd20, 0, 0, 32'd10);
    expect_bin(0, 5'd22, 0, 0, 32'd10);
    expect_bin(0, 5'd21, 0, 0, 32'd0);

    // dcache_miss stalls, then an out-of-range reason
    en = 1; stall_v = 1; reason = 5'd4;
    repeat (7) @(negedge clk);
    reason = 5'd25;
    repeat (3) @(negedge clk);
    en = 0;
    expect_bin(0, 5'd4, 0, 0, 32'd7);
    expect_bin(0, 5'd21, 0, 0, 32'd3);

    // read-and-clear bin 4 while reason 4 is counted in the acceptance cycle
    reason = 5'd4;
    expect_bin(0, 5'd4, 1, 1, 32'd7);
    expect_bin(0, 5'd4, 0, 0, 32'd1);
    stall_v = 0;

    // invalid index, response held for 5 cycles
    sel4 = 0; req_idx = 5'd30; req_clear = 1; req_v = 1;
    @(negedge clk);
    req_v = 0; req_clear = 0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("err hold resp_v c%0d", k), {31'b0, resp_v0}, 32'd1);
      chk($sformatf("err hold data c%0d", k), resp_data0, 32'd0);
      chk($sformatf("err hold err c%0d", k), {31'b0, resp_err0}, 32'd1);
      chk($sformatf("err hold ready c%0d", k), {31'b0, req_ready0}, 32'd0);
      @(negedge clk);
    end
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    chk("err resp_v drop", {31'b0, resp_v0}, 32'd0);
    $display("read dut32 bin 30 -> error response held 5 cycles");
    expect_bin(0, 5'd4, 0, 0, 32'd1);
    expect_bin(0, 5'd20, 0, 0, 32'd10);
    expect_bin(0, 5'd21, 0, 0, 32'd3);
    expect_bin(0, 5'd22, 0, 0, 32'd21);

    // clearing the total bin leaves the others alone
    expect_bin(0, 5'd22, 1, 0, 32'd21);
    expect_bin(0, 5'd20, 0, 0, 32'd10);
    expect_bin(0, 5'd22, 0, 0, 32'd0);
    expect_bin(0, 5'd4, 0, 0, 32'd1);

    // 4-bit instance saturation
    en4 = 1; commit4 = 1;
    repeat (20) @(negedge clk);
    en4 = 0; commit4 = 0;
    expect_bin(1, 5'd20, 0, 0, 32'd15);
    expect_bin(1, 5'd22, 0, 0, 32'd15);
    expect_bin(1, 5'd21, 0, 0, 32'd0);

    // reset in the middle of a response
    sel4 = 0; req_idx = 5'd20; req_v = 1;
    @(negedge clk);
    req_v = 0;
    chk("pre-reset resp_v", {31'b0, resp_v0}, 32'd1);
    chk("pre-reset data", resp_data0, 32'd10);
    #2 reset_li = 1'b0;
    #1;
    chk("async drop resp_v", {31'b0, resp_v0}, 32'd0);
    chk("async clear data", resp_data0, 32'd0);
    chk("async ready low", {31'b0, req_ready0}, 32'd0);
    $display("reset asserted mid-response");
    @(negedge clk);
    reset_li = 1'b1;
    @(negedge clk);
    chk("ready after 2nd reset", {31'b0, req_ready0}, 32'd1);
    expect_bin(0, 5'd20, 0, 0, 32'd0);
    expect_bin(0, 5'd22, 0, 0, 32'd0);
    expect_bin(0, 5'd4, 0, 0, 32'd0);
    expect_bin(0, 5'd21, 0, 0, 32'd0);
    expect_bin(1, 5'd20, 0, 0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
